// File: rtl/fp_sqr_issue_pkg.sv
// rtl/fp_sqr_issue_pkg.sv - shared encodings for the sqrt request sequencer
// Contents: FSM state encoding, exception flag bit order {inv,ov,un,inexact},
// single-precision quiet NaN and the rounding-mode codes used by the sqrt unit.
package fp_sqr_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sqr_state_t;

  // Bit positions inside a 4-bit flag vector.
  localparam int FLAG_INV = 3;
  localparam int FLAG_OV  = 2;
  localparam int FLAG_UN  = 1;
  localparam int FLAG_NX  = 0;

  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

  // Rounding modes, same encoding as the FPU round_m field.
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Flags reported when the sqrt unit never answers: invalid only.
  function automatic logic [3:0] tmo_flags();
    logic [3:0] f;
    f = '0;
    f[FLAG_INV] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/fp_sqr_issue_if.sv
// rtl/fp_sqr_issue_if.sv - request/response channels of the sqrt sequencer
// Request channel: req_valid/req_ready handshake carrying req_op, req_rm, req_tag.
// Response channel: rsp_valid/rsp_ready handshake carrying rsp_data, rsp_flags,
// rsp_tag, rsp_tmo.
// master: the requester/consumer side. slave: the sequencer.
interface fp_sqr_issue_if #(
  parameter int W    = 32,
  parameter int TAGW = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [W-1:0]    req_op;
  logic [2:0]      req_rm;
  logic [TAGW-1:0] req_tag;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [3:0]      rsp_flags;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_tmo;

  modport master (
    output req_valid, req_op, req_rm, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_tmo
  );

  modport slave (
    input  req_valid, req_op, req_rm, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_tmo
  );
endinterface

// File: rtl/fp_sqr_issue_fifo.sv
// rtl/fp_sqr_issue_fifo.sv - DEPTH-deep circular request queue
// Ports: clk, rst (async, active-high); push/wdata write the tail, pop advances
// the head, rdata shows the head entry; full/empty derived from the entry count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fp_req_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [NW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == NW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fp_sqr_issue.sv
// rtl/fp_sqr_issue.sv - request sequencer in front of the FPU square-root unit
// Ports:
//   clk, rst          clock, async active-high reset
//   bus (slave)       request queue input and response output channels
//   unit_in/unit_rm   operand and rounding mode to the sqrt unit, held stable
//   unit_act          one-cycle start pulse
//   unit_done/out/flags  result strobe, result and {inv,ov,un,inexact}
//   acc_flags/acc_clr sticky OR of delivered flags and its clear
module fp_sqr_issue
  import fp_sqr_issue_pkg::*;
#(
  parameter int W       = 32,
  parameter int DEPTH   = 2,
  parameter int TAGW    = 4,
  parameter int MIN_LAT = 2,
  parameter int TMO     = 63
) (
  input  logic         clk,
  input  logic         rst,
  fp_sqr_issue_if.slave bus,
  output logic [W-1:0] unit_in,
  output logic [2:0]   unit_rm,
  output logic         unit_act,
  input  logic         unit_done,
  input  logic [W-1:0] unit_out,
  input  logic [3:0]   unit_flags,
  output logic [3:0]   acc_flags,
  input  logic         acc_clr
);
  localparam int EW = W + 3 + TAGW;
  localparam int CW = $clog2(TMO + 1);

  sqr_state_t      state;
  logic [CW-1:0]   wait_cnt;
  logic [TAGW-1:0] work_tag;

  logic            q_full;
  logic            q_empty;
  logic [EW-1:0]   head;
  logic [W-1:0]    head_op;
  logic [2:0]      head_rm;
  logic [TAGW-1:0] head_tag;
  logic            rsp_hs;
  logic            take_next;
  logic            done_ok;

  assign {head_op, head_rm, head_tag} = head;

  // Only registered queue state feeds req_ready.
  assign bus.req_ready = ~q_full;
  assign rsp_hs        = bus.rsp_valid & bus.rsp_ready;

  // A new op starts from IDLE, or straight out of RESP on the handshake.
  assign take_next = ~q_empty &
                     ((state == ST_IDLE) | ((state == ST_RESP) & bus.rsp_ready));

  // A done seen too soon after issue may be left over from the previous op.
  assign done_ok = unit_done & (wait_cnt >= CW'(MIN_LAT));

  fp_req_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req_valid),
    .wdata ({bus.req_op, bus.req_rm, bus.req_tag}),
    .pop   (take_next),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      work_tag      <= '0;
      unit_in       <= '0;
      unit_rm       <= '0;
      unit_act      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_flags <= '0;
      bus.rsp_tag   <= '0;
      bus.rsp_tmo   <= 1'b0;
    end else begin
      unit_act <= 1'b0;
      case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_ok) begin
            bus.rsp_data  <= unit_out;
            bus.rsp_flags <= unit_flags;
            bus.rsp_tmo   <= 1'b0;
            bus.rsp_tag   <= work_tag;
            bus.rsp_valid <= 1'b1;
            state         <= ST_RESP;
          end else if (wait_cnt == CW'(TMO)) begin
            bus.rsp_data  <= W'(QNAN_SP);
            bus.rsp_flags <= tmo_flags();
            bus.rsp_tmo   <= 1'b1;
            bus.rsp_tag   <= work_tag;
            bus.rsp_valid <= 1'b1;
            state         <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Overrides the IDLE/RESP transitions above when a queued op is taken.
      if (take_next) begin
        unit_in  <= head_op;
        unit_rm  <= head_rm;
        work_tag <= head_tag;
        unit_act <= 1'b1;
        state    <= ST_ISSUE;
      end
    end
  end

  // Clear takes effect before the OR, so a coincident handshake survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_flags <= '0;
    end else if (acc_clr) begin
      acc_flags <= rsp_hs ? bus.rsp_flags : 4'b0000;
    end else if (rsp_hs) begin
      acc_flags <= acc_flags | bus.rsp_flags;
    end
  end
endmodule

// File: tb/tb_fp_sqr_issue.sv
// tb/tb_fp_sqr_issue.sv - self-checking bench for fp_sqr_issue
module tb_fp_sqr_issue;
  import fp_sqr_issue_pkg::*;

  localparam int W     = 32;
  localparam int TAGW  = 4;
  localparam int NEVER = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] unit_in;
  logic [2:0]   unit_rm;
  logic         unit_act;
  logic         unit_done;
  logic [W-1:0] unit_out;
  logic [3:0]   unit_flags;
  logic [3:0]   acc_flags;
  logic         acc_clr;

  fp_sqr_issue_if #(.W(W), .TAGW(TAGW)) bus ();

  fp_sqr_issue #(
    .W(W), .DEPTH(2), .TAGW(TAGW), .MIN_LAT(2), .TMO(63)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .unit_in    (unit_in),
    .unit_rm    (unit_rm),
    .unit_act   (unit_act),
    .unit_done  (unit_done),
    .unit_out   (unit_out),
    .unit_flags (unit_flags),
    .acc_flags  (acc_flags),
    .acc_clr    (acc_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op;
    logic [2:0]  rm;
    logic [3:0]  tag;
    logic [31:0] res;
    logic [3:0]  fl;
    int          k;
    logic [31:0] exp_data;
    logic [3:0]  exp_fl;
    logic        exp_tmo;
  } vec_t;

  typedef struct {
    logic [31:0] op;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [3:0]  fl;
    int          k;
  } unit_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  fl;
    logic [3:0]  tag;
    logic        tmo;
  } exp_t;

  unit_t      unit_q[$];
  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_acc;
  logic       hold_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] op, input logic [2:0] rm, input logic [3:0] tag,
                              input logic [31:0] res, input logic [3:0] fl, input int k);
    vec_t v;
    v.op = op; v.rm = rm; v.tag = tag; v.res = res; v.fl = fl; v.k = k;
    v.exp_tmo  = (k == NEVER);
    v.exp_data = v.exp_tmo ? 32'h7FC0_0000 : res;
    v.exp_fl   = v.exp_tmo ? 4'b1000 : fl;
    return v;
  endfunction

  // Sqrt unit model: raises done k cycles into WAIT (k == NEVER: stays silent).
  initial begin : unit_model
    logic  busy;
    int    wcnt;
    unit_t cur;
    busy = 1'b0; wcnt = 0;
    unit_done = 1'b0; unit_out = '0; unit_flags = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
        unit_done = 1'b0;
      end else begin
        if (!hold_done) unit_done = 1'b0;
        if (busy) begin
          if (wcnt == cur.k) begin
            unit_done = 1'b1; unit_out = cur.res; unit_flags = cur.fl; busy = 1'b0;
            check("unit_in_held", unit_in, cur.op);
          end else begin
            wcnt++;
          end
        end
        if (unit_act) begin
          check("unit_act_expected", unit_q.size() > 0, 1);
          if (unit_q.size() > 0) begin
            cur = unit_q.pop_front();
            check("unit_in", unit_in, cur.op);
            check("unit_rm", unit_rm, cur.rm);
            busy = (cur.k != NEVER);
            wcnt = 0;
          end
        end
      end
    end
  end

  // Response scoreboard and acc_flags reference.
  initial begin : rsp_monitor
    exp_t e;
    exp_acc = 4'b0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_acc = 4'b0000;
      end else begin
        check("acc_flags", acc_flags, exp_acc);
        if (bus.rsp_valid && bus.rsp_ready) begin
          check("rsp_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rsp_data", bus.rsp_data, e.data);
            check("rsp_flags", bus.rsp_flags, e.fl);
            check("rsp_tag", bus.rsp_tag, e.tag);
            check("rsp_tmo", bus.rsp_tmo, e.tmo);
            exp_acc = (acc_clr ? 4'b0000 : exp_acc) | e.fl;
          end
        end else if (acc_clr) begin
          exp_acc = 4'b0000;
        end
      end
    end
  end

  task automatic send(input vec_t v);
    unit_t u;
    exp_t  e;
    int    n;
    u.op = v.op; u.rm = v.rm; u.res = v.res; u.fl = v.fl; u.k = v.k;
    e.data = v.exp_data; e.fl = v.exp_fl; e.tag = v.tag; e.tmo = v.exp_tmo;
    bus.req_valid = 1'b1; bus.req_op = v.op; bus.req_rm = v.rm; bus.req_tag = v.tag;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 200);
    check("req_accept", bus.req_ready, 1);
    if (bus.req_ready) begin
      unit_q.push_back(u);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    check("drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Cycles from the accept edge until rsp_valid is seen.
  task automatic latency(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.rsp_valid && n < 200);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vec_t tbl[6];
    int   n;
    int   seen;

    tbl[0] = '{32'h4110_0000, RM_RNE, 4'd5, 32'h4040_0000, 4'b0000, 2,  32'h4040_0000, 4'b0000, 1'b0};
    tbl[1] = '{32'h4000_0000, RM_RTZ, 4'd6, 32'h3FB5_04F3, 4'b0001, 4,  32'h3FB5_04F3, 4'b0001, 1'b0};
    tbl[2] = '{32'hBF80_0000, RM_RNE, 4'd7, 32'h7FC0_0000, 4'b1000, 3,  32'h7FC0_0000, 4'b1000, 1'b0};
    tbl[3] = '{32'h0000_0000, RM_RDN, 4'd8, 32'h0000_0000, 4'b0000, 7,  32'h0000_0000, 4'b0000, 1'b0};
    tbl[4] = '{32'h3E80_0000, RM_RUP, 4'd9, 32'h3F00_0000, 4'b0000, 2,  32'h3F00_0000, 4'b0000, 1'b0};
    tbl[5] = '{32'h4180_0000, RM_RMM, 4'd10, 32'h4080_0000, 4'b0000, 63, 32'h4080_0000, 4'b0000, 1'b0};

    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rm = '0; bus.req_tag = '0;
    bus.rsp_ready = 1'b0; acc_clr = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_unit_act", unit_act, 0);
    check("rst_unit_in", unit_in, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_acc", acc_flags, 0);
    // Request while in reset must be dropped.
    bus.req_valid = 1'b1; bus.req_op = 32'h4080_0000; bus.req_tag = 4'd1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (unit_act || bus.rsp_valid) seen++;
    end
    check("rst_req_ignored", seen, 0);

    // Single request latency.
    bus.rsp_ready = 1'b1;
    send(mk(32'h4080_0000, RM_RNE, 4'd3, 32'h4000_0000, 4'b0000, 2));
    latency(n);
    check("lat_single", n, 5);
    check("lat_rsp_data", bus.rsp_data, 32'h4000_0000);
    drain(100);
    check("acc_after_single", acc_flags, 4'b0000);

    // Table vectors back to back through the queue.
    for (int i = 0; i < 6; i++) send(tbl[i]);
    drain(2000);

    // Queue fill with response stalled, then in-order release.
    bus.rsp_ready = 1'b0;
    send(mk(32'h4110_0000, RM_RNE, 4'd0, 32'h4040_0000, 4'b0000, 2));
    send(mk(32'h4180_0000, RM_RNE, 4'd1, 32'h4080_0000, 4'b0000, 2));
    send(mk(32'h4200_0000, RM_RNE, 4'd2, 32'h40B5_04F3, 4'b0001, 2));
    check("full_req_ready", bus.req_ready, 0);
    repeat (10) @(posedge clk);
    #1;
    check("stall_rsp_valid", bus.rsp_valid, 1);
    check("stall_rsp_tag", bus.rsp_tag, 0);
    check("stall_req_ready", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    drain(200);

    // Stale done held high into the next op.
    hold_done = 1'b1;
    send(mk(32'h4190_0000, RM_RNE, 4'd4, 32'h4080_0000, 4'b0100, 2));
    send(mk(32'h4210_0000, RM_RNE, 4'd5, 32'h40C0_0000, 4'b0010, 2));
    drain(200);
    hold_done = 1'b0;
    @(posedge clk);
    #1;

    // Timeout completion.
    send(mk(32'h4080_0000, RM_RNE, 4'd12, 32'h0, 4'b0000, NEVER));
    latency(n);
    check("lat_timeout", n, 66);
    drain(200);
    check("acc_inv_after_tmo", acc_flags[3], 1);

    // Flag accumulation with clear.
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("acc_clr_alone", acc_flags, 4'b0000);
    send(mk(32'h4080_0000, RM_RNE, 4'd1, 32'h4000_0000, 4'b0001, 2));
    drain(100);
    check("acc_0001", acc_flags, 4'b0001);
    send(mk(32'h4080_0000, RM_RNE, 4'd2, 32'h4000_0000, 4'b0100, 3));
    drain(100);
    check("acc_0101", acc_flags, 4'b0101);
    bus.rsp_ready = 1'b0;
    send(mk(32'h4080_0000, RM_RNE, 4'd3, 32'h4000_0000, 4'b0010, 2));
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("acc_rsp_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("acc_clr_with_hs", acc_flags, 4'b0010);
    drain(100);

    // Reset during WAIT with one entry queued.
    send(mk(32'h4080_0000, RM_RNE, 4'd10, 32'h0, 4'b0000, NEVER));
    send(mk(32'h4110_0000, RM_RNE, 4'd11, 32'h4040_0000, 4'b0000, 2));
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    sb_q.delete();
    unit_q.delete();
    #1;
    check("mid_rst_unit_act", unit_act, 0);
    check("mid_rst_unit_in", unit_in, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_req_ready", bus.req_ready, 1);
    check("mid_rst_acc", acc_flags, 0);
    check("mid_rst_rsp_data", bus.rsp_data, 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid || unit_act) seen++;
    end
    check("post_rst_quiet", seen, 0);
    send(mk(32'h4180_0000, RM_RNE, 4'd13, 32'h4080_0000, 4'b0001, 2));
    latency(n);
    check("post_rst_lat", n, 5);
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_sqr_issue.md
Name: fp_sqr_issue

Overview:
Request sequencer placed directly upstream of the FPU square-root unit.
- Accepts operand/rounding-mode requests through a valid/ready queue.
- Presents one operand at a time, held stable, to the sqrt unit.
- Waits for the unit's done, with a timeout guard, then returns result, exception flags and tag through a valid/ready response port.
- Keeps a sticky accumulated-flags register for the FPU status path.

Parameters:
W, 32, operand/result width (IEEE-754 single).
DEPTH, 2, request queue entries; power of two, at least 2.
TAGW, 4, request tag width.
MIN_LAT, 2, cycles after issue during which unit_done is ignored, to mask a stale done from the previous operation.
TMO, 63, WAIT-state cycle limit before forced timeout completion; TMO must exceed MIN_LAT.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  queue can accept; high when count < DEPTH.
req_op  in  W  operand.
req_rm  in  3  rounding mode, same encoding as the FPU's round_m.
req_tag  in  TAGW  request identifier, returned unchanged.
unit_in  out  W  operand to the sqrt unit.
unit_rm  out  3  rounding mode to the sqrt unit.
unit_act  out  1  one-cycle start pulse.
unit_done  in  1  sqrt unit result valid.
unit_out  in  W  sqrt unit result.
unit_flags  in  4  {inv,ov,un,inexact} from the sqrt unit.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts.
rsp_data  out  W  result.
rsp_flags  out  4  {inv,ov,un,inexact}.
rsp_tag  out  TAGW  tag of the completed request.
rsp_tmo  out  1  response was forced by timeout.
acc_flags  out  4  sticky OR of all delivered rsp_flags.
acc_clr  in  1  clear acc_flags.

Behaviour:
Reset (rst high, async):
- State IDLE, queue empty, wait counter 0.
- All outputs 0 except req_ready, which is 1 (count = 0).
- Requests presented while rst is high are ignored.
- Asserting rst mid-operation discards the in-flight op and all queued entries; no response is produced for them.

Queue:
- Circular buffer with rd/wr pointers (log2 DEPTH bits, wrap modulo DEPTH) and a count.
- Push on req_valid & req_ready. Pop when the FSM leaves IDLE or RESP into ISSUE.
- Push and pop in the same cycle leaves count unchanged. No push when full, since req_ready is low.
- req_ready depends only on registered count; there is no combinational path from rsp_ready.

FSM: IDLE, ISSUE, WAIT, RESP.
- IDLE: queue non-empty -> ISSUE. The head {op,rm,tag} is latched into the working register and popped.
- ISSUE (1 cycle): unit_act = 1; unit_in/unit_rm driven from the working register. Counter cleared. -> WAIT.
- WAIT: unit_in/unit_rm held stable; counter increments each cycle.
  - unit_done sampled only when counter >= MIN_LAT.
  - Sampled done: capture unit_out and unit_flags into the response registers, rsp_tmo = 0, -> RESP.
  - counter == TMO without done: rsp_data = 0x7FC00000 (quiet NaN), rsp_flags = 4'b1000, rsp_tmo = 1, -> RESP.
  - Done and timeout in the same cycle: done wins.
- RESP: rsp_valid = 1; rsp_data/flags/tag/tmo stable until handshake.
  - On rsp_ready: if the queue is non-empty, -> ISSUE directly, popping the next entry in the same cycle. Otherwise -> IDLE.
  - rsp_valid drops the cycle after the handshake.
- unit_in/unit_rm keep their last value outside WAIT/ISSUE (no toggling).

Latency: accepted request at cycle t with FSM idle and unit done at WAIT count k (k >= MIN_LAT) gives rsp_valid at t+3+k. Back-to-back throughput is one op per (k+3) cycles.

acc_flags:
- On rsp handshake, acc <= acc | rsp_flags.
- acc_clr alone: acc <= 0.
- acc_clr coincident with a handshake: acc <= rsp_flags (clear first, then OR).

Decomposition:
- Shared package (fpu_pkg): FSM state encoding, the flag bit order {inv,ov,un,inexact}, the quiet-NaN constant, and rounding-mode codes shared with the sqrt unit.
- One natural sub-module: fp_req_fifo (parameterized W+3+TAGW wide, DEPTH-deep circular queue with count and full/empty). The FSM and flag accumulation stay in the top.

Test Plan:
1. Single request op=0x40800000 (4.0), rm=RNe, tag=3; unit returns 0x40000000, flags 0000 at WAIT count 2 -> rsp_valid at t+5 with data 0x40000000, tag 3, rsp_tmo 0, acc_flags 0000.
2. Three back-to-back requests with DEPTH=2 and rsp_ready held low -> req_ready low after the third accept. Release rsp_ready -> responses in order, tags 0,1,2; no loss or duplication across pointer wrap.
3. unit_done held high from the previous op during the first MIN_LAT WAIT cycles -> ignored. Only done at count >= 2 is captured, carrying the correct second result.
4. unit_done never asserted -> after TMO=63 WAIT cycles: rsp_data 0x7FC00000, rsp_flags 1000, rsp_tmo 1; acc_flags bit inv set after handshake.
5. Responses with flags 0001 then 0100, then acc_clr coincident with a handshake carrying 0010 -> acc_flags 0001, 0101, then 0010.
6. rst pulsed during WAIT with one entry queued -> all outputs 0, req_ready 1, no response for either discarded op. A new request after reset completes normally.
